// File: rtl/register_bank_nbit.sv
// Register bank of NUM_REGS N-bit registers with one write/modify port and two combinational read ports.
// Define REGBANK_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module register_bank_nbit #(
    parameter int unsigned N        = 8,
    parameter int unsigned NUM_REGS = 4,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      data_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [N-1:0]      rd_data_a,
    output logic [N-1:0]      rd_data_b,
    output logic              carry_out,
    output logic              zero_out
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_DEC  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;

    logic [N-1:0] regs [NUM_REGS];
    logic [N-1:0] old_val;
    logic [N-1:0] result;
    logic         carry_nxt;
    logic         op_ok;
    logic         wr_ok;
    logic         exec;

    // Result and carry of the op presented on the write port
    always_comb begin
        result    = '0;
        carry_nxt = 1'b0;
        op_ok     = 1'b1;
        wr_ok     = (32'(wr_addr) < NUM_REGS);
        old_val   = '0;
        if (wr_ok) begin
            old_val = regs[wr_addr];
        end
        case (op)
            OP_LOAD: result = data_in;
            OP_INC:  {carry_nxt, result} = {1'b0, old_val} + {{N{1'b0}}, 1'b1};
            OP_DEC: begin
                result    = old_val - {{(N-1){1'b0}}, 1'b1};
                carry_nxt = (old_val == '0);
            end
            OP_SHL: begin
                result    = {old_val[N-2:0], 1'b0};
                carry_nxt = old_val[N-1];
            end
            OP_SHR: begin
                result    = {1'b0, old_val[N-1:1]};
                carry_nxt = old_val[0];
            end
            OP_CLR:  result = '0;
            default: op_ok = 1'b0;
        endcase
        exec = we && op_ok && wr_ok;
    end

    // Read ports; out-of-range addresses read as zero
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (32'(rd_addr_a) < NUM_REGS) begin
            rd_data_a = regs[rd_addr_a];
        end
        if (32'(rd_addr_b) < NUM_REGS) begin
            rd_data_b = regs[rd_addr_b];
        end
`ifdef REGBANK_BYPASS_EN
        if (exec && !reset && (rd_addr_a == wr_addr)) begin
            rd_data_a = result;
        end
        if (exec && !reset && (rd_addr_b == wr_addr)) begin
            rd_data_b = result;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
        end else if (exec) begin
            regs[wr_addr] <= result;
            carry_out     <= carry_nxt;
            zero_out      <= (result == '0);
        end
    end

endmodule

// File: tb/tb_register_bank_nbit.sv
// Self-checking bench for register_bank_nbit: vector table with an expectation queue,
// plus hand-written same-cycle, reset and out-of-range sequences.
module tb_register_bank_nbit;

    localparam logic [2:0] LD = 3'd0, INC = 3'd1, DEC = 3'd2, SHL = 3'd3,
                           SHR = 3'd4, CLR = 3'd5, R6 = 3'd6, R7 = 3'd7;
`ifdef REGBANK_BYPASS_EN
    localparam logic [7:0] EXP_SAME = 8'h11;
`else
    localparam logic [7:0] EXP_SAME = 8'h10;
`endif

    logic       clk = 1'b0;
    logic       reset, we;
    logic [2:0] op;
    logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [7:0] data_in, rd_data_a, rd_data_b;
    logic       carry_out, zero_out;

    logic       x_reset, x_we;
    logic [2:0] x_op;
    logic [1:0] x_wr_addr, x_rd_addr_a, x_rd_addr_b;
    logic [7:0] x_data_in, x_rd_data_a, x_rd_data_b;
    logic       x_carry_out, x_zero_out;

    always #5 clk = ~clk;

    register_bank_nbit #(.N(8), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .we(we), .op(op), .wr_addr(wr_addr),
        .data_in(data_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .carry_out(carry_out), .zero_out(zero_out)
    );

    register_bank_nbit #(.N(8), .NUM_REGS(3)) dut3 (
        .clk(clk), .reset(x_reset), .we(x_we), .op(x_op), .wr_addr(x_wr_addr),
        .data_in(x_data_in), .rd_addr_a(x_rd_addr_a), .rd_addr_b(x_rd_addr_b),
        .rd_data_a(x_rd_data_a), .rd_data_b(x_rd_data_b),
        .carry_out(x_carry_out), .zero_out(x_zero_out)
    );

    typedef struct packed {
        logic       we;
        logic [2:0] op;
        logic [1:0] wa;
        logic [7:0] din;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ec;
        logic       ez;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[18];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one op, let it execute, then read back with the write port idle
    task automatic apply(input vec_t v, input string tag);
        exp_t e, got;
        @(negedge clk);
        we = v.we; op = v.op; wr_addr = v.wa; data_in = v.din;
        rd_addr_a = v.ra; rd_addr_b = v.rb;
        e.a = v.ea; e.b = v.eb; e.c = v.ec; e.z = v.ez;
        sbq.push_back(e);
        @(posedge clk);
        #1 we = 1'b0;
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            got = sbq.pop_front();
            chk({tag, "_rd_a"}, 32'(rd_data_a), 32'(got.a));
            chk({tag, "_rd_b"}, 32'(rd_data_b), 32'(got.b));
            chk({tag, "_carry"}, 32'(carry_out), 32'(got.c));
            chk({tag, "_zero"}, 32'(zero_out), 32'(got.z));
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] o, input logic [1:0] wa,
                                input logic [7:0] d, input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] ea, input logic [7:0] eb,
                                input logic ec, input logic ez);
        vec_t v;
        v.we = w; v.op = o; v.wa = wa; v.din = d; v.ra = ra; v.rb = rb;
        v.ea = ea; v.eb = eb; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1, LD,  1, 8'hA5, 1, 2, 8'hA5, 8'h00, 0, 0);
        tbl[1]  = mk(1, LD,  2, 8'h3C, 1, 2, 8'hA5, 8'h3C, 0, 0);
        tbl[2]  = mk(1, LD,  0, 8'hFF, 0, 1, 8'hFF, 8'hA5, 0, 0);
        tbl[3]  = mk(1, INC, 0, 8'h00, 0, 2, 8'h00, 8'h3C, 1, 1);
        tbl[4]  = mk(1, DEC, 0, 8'h00, 0, 2, 8'hFF, 8'h3C, 1, 0);
        tbl[5]  = mk(1, LD,  3, 8'h81, 3, 0, 8'h81, 8'hFF, 0, 0);
        tbl[6]  = mk(1, SHL, 3, 8'h00, 3, 0, 8'h02, 8'hFF, 1, 0);
        tbl[7]  = mk(1, SHR, 3, 8'h00, 3, 0, 8'h01, 8'hFF, 0, 0);
        tbl[8]  = mk(1, SHR, 3, 8'h00, 3, 0, 8'h00, 8'hFF, 1, 1);
        tbl[9]  = mk(1, R7,  1, 8'h55, 1, 3, 8'hA5, 8'h00, 1, 1);
        tbl[10] = mk(0, LD,  1, 8'h00, 1, 3, 8'hA5, 8'h00, 1, 1);
        tbl[11] = mk(1, CLR, 2, 8'h77, 2, 1, 8'h00, 8'hA5, 0, 1);
        tbl[12] = mk(1, LD,  2, 8'h00, 2, 2, 8'h00, 8'h00, 0, 1);
        tbl[13] = mk(1, DEC, 3, 8'h00, 3, 0, 8'hFF, 8'hFF, 1, 0);
        tbl[14] = mk(1, INC, 1, 8'h00, 1, 1, 8'hA6, 8'hA6, 0, 0);
        tbl[15] = mk(1, R6,  1, 8'h00, 1, 1, 8'hA6, 8'hA6, 0, 0);
        tbl[16] = mk(1, SHR, 0, 8'h00, 0, 3, 8'h7F, 8'hFF, 1, 0);
        tbl[17] = mk(1, SHL, 0, 8'h00, 0, 3, 8'hFE, 8'hFF, 0, 0);

        reset = 1'b1; we = 1'b0; op = LD; wr_addr = '0; data_in = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        x_reset = 1'b1; x_we = 1'b0; x_op = LD; x_wr_addr = '0; x_data_in = '0;
        x_rd_addr_a = '0; x_rd_addr_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; x_reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
            #1;
            chk($sformatf("reset_rd_a%0d", i), 32'(rd_data_a), 32'h00);
            chk($sformatf("reset_rd_b%0d", i), 32'(rd_data_b), 32'h00);
        end
        chk("reset_carry", 32'(carry_out), 32'd0);
        chk("reset_zero", 32'(zero_out), 32'd0);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Same-cycle read of the register being modified
        apply(mk(1, LD, 1, 8'h10, 1, 0, 8'h10, 8'hFE, 0, 0), "ld10");
        @(negedge clk);
        we = 1'b1; op = INC; wr_addr = 2'd1; rd_addr_a = 2'd1; rd_addr_b = 2'd2;
        #1;
        chk("same_cycle_rd_a", 32'(rd_data_a), 32'(EXP_SAME));
        chk("same_cycle_rd_b_other", 32'(rd_data_b), 32'h00);
        @(posedge clk);
        #1 we = 1'b0;
        #1;
        chk("next_cycle_rd_a", 32'(rd_data_a), 32'h11);

        // Reserved op never forwards
        @(negedge clk);
        we = 1'b1; op = R7; wr_addr = 2'd1; rd_addr_a = 2'd1;
        #1;
        chk("reserved_no_fwd", 32'(rd_data_a), 32'h11);
        @(posedge clk);
        #1 we = 1'b0;

        // Set carry, then reset with a LOAD pending
        apply(mk(1, LD, 3, 8'h00, 3, 1, 8'h00, 8'h11, 0, 1), "ld3_0");
        apply(mk(1, DEC, 3, 8'h00, 3, 1, 8'hFF, 8'h11, 1, 0), "dec3");
        @(negedge clk);
        reset = 1'b1; we = 1'b1; op = LD; wr_addr = 2'd1; data_in = 8'hFF; rd_addr_a = 2'd1;
        #1;
        chk("reset_cycle_no_fwd", 32'(rd_data_a), 32'h11);
        @(posedge clk);
        #1 reset = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            #1;
            chk($sformatf("post_reset_r%0d", i), 32'(rd_data_a), 32'h00);
        end
        chk("post_reset_carry", 32'(carry_out), 32'd0);
        chk("post_reset_zero", 32'(zero_out), 32'd0);

        // Three-register bank: address 3 is out of range
        @(negedge clk);
        x_we = 1'b1; x_op = LD; x_wr_addr = 2'd2; x_data_in = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        x_op = LD; x_wr_addr = 2'd3; x_data_in = 8'h00; x_rd_addr_a = 2'd3; x_rd_addr_b = 2'd2;
        #1;
        chk("oor_same_cycle_rd3", 32'(x_rd_data_a), 32'h00);
        @(posedge clk);
        #1 x_we = 1'b0;
        #1;
        chk("oor_rd3", 32'(x_rd_data_a), 32'h00);
        chk("oor_rd2_hold", 32'(x_rd_data_b), 32'h5A);
        chk("oor_zero_hold", 32'(x_zero_out), 32'd0);
        chk("oor_carry_hold", 32'(x_carry_out), 32'd0);
        for (int i = 0; i < 2; i++) begin
            x_rd_addr_a = 2'(i);
            #1;
            chk($sformatf("oor_r%0d_untouched", i), 32'(x_rd_data_a), 32'h00);
        end

        chk("queue_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
